// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-issue CPU and its control sequencer:
//   - datapath widths (D_WIDTH, A_WIDTH) and control widths (OP_SIZE,
//     OP_CODE_SIZE) used by alu, cpu_ctrl and the top level
//   - sequencer state enum and decoded instruction class enum
//   - RV32I opcode constants for the supported subset
//   - alu operation codes and immediate-format select codes
//   - helper that maps funct3 onto the alu operation
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int D_WIDTH      = 32;
  localparam int A_WIDTH      = 32;
  localparam int OP_SIZE      = 4;
  localparam int OP_CODE_SIZE = 7;

  // Sequencer states; the encoding is also exported on the debug state port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  // Instruction class produced by the decoder and latched for EXEC/MEM/WB.
  typedef enum logic [2:0] {
    CLS_R  = 3'd0,
    CLS_I  = 3'd1,
    CLS_LD = 3'd2,
    CLS_ST = 3'd3,
    CLS_BR = 3'd4
  } iclass_e;

  localparam logic [OP_CODE_SIZE-1:0] OPC_R  = 7'b0110011;
  localparam logic [OP_CODE_SIZE-1:0] OPC_I  = 7'b0010011;
  localparam logic [OP_CODE_SIZE-1:0] OPC_LD = 7'b0000011;
  localparam logic [OP_CODE_SIZE-1:0] OPC_ST = 7'b0100011;
  localparam logic [OP_CODE_SIZE-1:0] OPC_BR = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OP_SIZE-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_SIZE-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_SIZE-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_SIZE-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_SIZE-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_SIZE-1:0] ALU_SLL  = 4'b0101;
  localparam logic [OP_SIZE-1:0] ALU_SRL  = 4'b0110;
  localparam logic [OP_SIZE-1:0] ALU_SRA  = 4'b0111;
  localparam logic [OP_SIZE-1:0] ALU_SLT  = 4'b1000;
  localparam logic [OP_SIZE-1:0] ALU_SLTU = 4'b1001;
  localparam logic [OP_SIZE-1:0] ALU_NOP  = 4'b1111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // funct3 -> alu op. 'alt' selects the funct7=0100000 flavour (SUB/SRA)
  // for the two funct3 codes that have one; it is ignored elsewhere.
  function automatic logic [OP_SIZE-1:0] alu_from_funct3(input logic [2:0] funct3,
                                                         input logic       alt);
    logic [OP_SIZE-1:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_if
// Bundle between the control sequencer and the datapath.
//   Datapath -> sequencer: opcode, funct3, funct7 (ir fields), alu_zero,
//                          dmem_ready (data_mem access done this cycle)
//   Sequencer -> datapath: pc_en, pc_sel, ir_en, rf_we, wb_sel, b_sel,
//                          imm_sel, alu_op, dmem_re, dmem_we, halted, state
// Modports:
//   master - the sequencer (cpu_ctrl)
//   slave  - the datapath side that consumes the strobes
// -----------------------------------------------------------------------------
interface cpu_ctrl_if;
  import cpu_pkg::*;

  logic [OP_CODE_SIZE-1:0] opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic                    alu_zero;
  logic                    dmem_ready;

  logic                    pc_en;
  logic                    pc_sel;
  logic                    ir_en;
  logic                    rf_we;
  logic                    wb_sel;
  logic                    b_sel;
  logic [1:0]              imm_sel;
  logic [OP_SIZE-1:0]      alu_op;
  logic                    dmem_re;
  logic                    dmem_we;
  logic                    halted;
  logic [2:0]              state;

  modport master (
    input  opcode, funct3, funct7, alu_zero, dmem_ready,
    output pc_en, pc_sel, ir_en, rf_we, wb_sel, b_sel, imm_sel, alu_op,
           dmem_re, dmem_we, halted, state
  );

  modport slave (
    output opcode, funct3, funct7, alu_zero, dmem_ready,
    input  pc_en, pc_sel, ir_en, rf_we, wb_sel, b_sel, imm_sel, alu_op,
           dmem_re, dmem_we, halted, state
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_decode
// Purely combinational RV32I-subset decoder.
//   in  opcode  - ir opcode field
//   in  funct3  - ir funct3 field
//   in  funct7  - ir funct7 field
//   out iclass  - instruction class (R, I, LD, ST, BR)
//   out alu_op  - alu operation to use in EXEC
//   out imm_sel - immediate format (I, S, B)
//   out b_sel   - alu operand B source (0 = rs2, 1 = immediate)
//   out legal   - instruction is part of the supported subset
// -----------------------------------------------------------------------------
module cpu_ctrl_decode #(
  parameter int OP_SIZE      = cpu_pkg::OP_SIZE,
  parameter int OP_CODE_SIZE = cpu_pkg::OP_CODE_SIZE
) (
  input  logic [OP_CODE_SIZE-1:0] opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  output cpu_pkg::iclass_e        iclass,
  output logic [OP_SIZE-1:0]      alu_op,
  output logic [1:0]              imm_sel,
  output logic                    b_sel,
  output logic                    legal
);
  import cpu_pkg::*;

  // Anything not explicitly accepted below falls through with legal=0,
  // which sends the sequencer to HALT.
  always_comb begin
    iclass  = CLS_R;
    alu_op  = ALU_NOP;
    imm_sel = IMM_I;
    b_sel   = 1'b0;
    legal   = 1'b0;

    case (opcode)
      OPC_R: begin
        iclass = CLS_R;
        if (funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = alu_from_funct3(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal  = 1'b1;
          alu_op = alu_from_funct3(funct3, 1'b1);
        end
      end

      // funct7 is immediate bits for I-ALU except on the shift encodings,
      // which is why only funct3 001/101 look at it.
      OPC_I: begin
        iclass = CLS_I;
        b_sel  = 1'b1;
        case (funct3)
          3'b001: begin
            legal  = (funct7 == F7_BASE);
            alu_op = ALU_SLL;
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              legal  = 1'b1;
              alu_op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              legal  = 1'b1;
              alu_op = ALU_SRA;
            end
          end
          default: begin
            legal  = 1'b1;
            alu_op = alu_from_funct3(funct3, 1'b0);
          end
        endcase
      end

      // Only word accesses are supported by data_mem.
      OPC_LD: begin
        iclass = CLS_LD;
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
        legal  = (funct3 == 3'b010);
      end

      OPC_ST: begin
        iclass  = CLS_ST;
        b_sel   = 1'b1;
        imm_sel = IMM_S;
        alu_op  = ALU_ADD;
        legal   = (funct3 == 3'b010);
      end

      // Branches compare rs1 and rs2 via SUB and look at alu_zero.
      OPC_BR: begin
        iclass  = CLS_BR;
        imm_sel = IMM_B;
        alu_op  = ALU_SUB;
        legal   = (funct3 == 3'b000 || funct3 == 3'b001);
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
// Multi-cycle control sequencer: walks each instruction through
// FETCH, DECODE, EXEC, (MEM), (WB) and drives the datapath strobes.
//   in  clk  - single clock, rising edge
//   in  rst  - asynchronous active-low reset; deassertion is expected to be
//              synchronised to clk by the reset generator
//   in  run  - leave IDLE and start fetching (only looked at in IDLE)
//   bus      - cpu_ctrl_if.master: ir fields, alu_zero, dmem_ready in;
//              pc/ir/rf/dmem strobes, selects, alu_op, halted, state out
// Outputs are Moore-decoded from the state and the decode latch, except the
// branch pc_en/pc_sel in EXEC and the store pc_en in MEM, which follow
// alu_zero and dmem_ready within the cycle.
// -----------------------------------------------------------------------------
module cpu_ctrl #(
  parameter int OP_SIZE      = cpu_pkg::OP_SIZE,
  parameter int OP_CODE_SIZE = cpu_pkg::OP_CODE_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  cpu_ctrl_if.master bus
);
  import cpu_pkg::*;

  state_e             state_q;
  state_e             state_d;

  iclass_e            dec_class;
  logic [OP_SIZE-1:0] dec_alu_op;
  logic [1:0]         dec_imm_sel;
  logic               dec_b_sel;
  logic               dec_legal;

  iclass_e            cls_q;
  logic [OP_SIZE-1:0] alu_op_q;
  logic [1:0]         imm_sel_q;
  logic               b_sel_q;
  logic               is_beq_q;

  cpu_ctrl_decode #(
    .OP_SIZE      (OP_SIZE),
    .OP_CODE_SIZE (OP_CODE_SIZE)
  ) u_decode (
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .iclass  (dec_class),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .b_sel   (dec_b_sel),
    .legal   (dec_legal)
  );

  // State register. Because every output is decoded from state_q, an
  // asserted rst pulls all strobes back to their idle values immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Decode latch, captured at the end of DECODE so that EXEC/MEM/WB see a
  // stable view of the instruction even if ir changes afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q     <= CLS_R;
      alu_op_q  <= ALU_NOP;
      imm_sel_q <= IMM_I;
      b_sel_q   <= 1'b0;
      is_beq_q  <= 1'b0;
    end else if (state_q == DECODE) begin
      cls_q     <= dec_class;
      alu_op_q  <= dec_alu_op;
      imm_sel_q <= dec_imm_sel;
      b_sel_q   <= dec_b_sel;
      is_beq_q  <= (bus.funct3 == 3'b000);
    end
  end

  assign bus.state = state_q;

  // Next-state and output decode. Each instruction retires with exactly one
  // pc_en: in EXEC for branches, in the ready MEM cycle for stores and in WB
  // for ALU ops and loads.
  always_comb begin
    state_d     = state_q;
    bus.pc_en   = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.ir_en   = 1'b0;
    bus.rf_we   = 1'b0;
    bus.wb_sel  = 1'b0;
    bus.b_sel   = 1'b0;
    bus.imm_sel = IMM_I;
    bus.alu_op  = ALU_NOP;
    bus.dmem_re = 1'b0;
    bus.dmem_we = 1'b0;
    bus.halted  = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        bus.ir_en = 1'b1;
        state_d   = DECODE;
      end

      DECODE: begin
        state_d = dec_legal ? EXEC : HALT;
      end

      EXEC: begin
        bus.alu_op  = alu_op_q;
        bus.b_sel   = b_sel_q;
        bus.imm_sel = imm_sel_q;
        case (cls_q)
          CLS_LD, CLS_ST: state_d = MEM;
          CLS_BR: begin
            bus.pc_en  = 1'b1;
            bus.pc_sel = is_beq_q ? bus.alu_zero : !bus.alu_zero;
            state_d    = FETCH;
          end
          default: state_d = WB;
        endcase
      end

      // The alu keeps computing rs1 + imm as the address while the request
      // is held; imm_sel keeps the load/store immediate format selected.
      MEM: begin
        bus.alu_op  = ALU_ADD;
        bus.b_sel   = 1'b1;
        bus.imm_sel = imm_sel_q;
        if (cls_q == CLS_ST) begin
          bus.dmem_we = 1'b1;
          if (bus.dmem_ready) begin
            bus.pc_en = 1'b1;
            state_d   = FETCH;
          end
        end else begin
          bus.dmem_re = 1'b1;
          if (bus.dmem_ready) begin
            state_d = WB;
          end
        end
      end

      WB: begin
        bus.rf_we  = 1'b1;
        bus.pc_en  = 1'b1;
        bus.wb_sel = (cls_q == CLS_LD);
        state_d    = FETCH;
      end

      HALT: begin
        bus.halted = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl
// Directed and randomised instruction sequences for cpu_ctrl. Expected
// behaviour comes from an instruction-level reference model: it classifies
// each instruction from the RV32I field rules, derives the cycle count and
// the cycle on which pc_en/rf_we/dmem strobes must appear, and the bench
// compares every cycle of the DUT against that.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl;
  import cpu_pkg::*;

  localparam logic [3:0] A_ADD  = 4'h0;
  localparam logic [3:0] A_SUB  = 4'h1;
  localparam logic [3:0] A_AND  = 4'h2;
  localparam logic [3:0] A_OR   = 4'h3;
  localparam logic [3:0] A_XOR  = 4'h4;
  localparam logic [3:0] A_SLL  = 4'h5;
  localparam logic [3:0] A_SRL  = 4'h6;
  localparam logic [3:0] A_SRA  = 4'h7;
  localparam logic [3:0] A_SLT  = 4'h8;
  localparam logic [3:0] A_SLTU = 4'h9;
  localparam logic [3:0] A_NOP  = 4'hF;

  localparam logic [3:0] F3_TAB [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU,
                                        A_XOR, A_SRL, A_OR, A_AND};

  localparam int K_R  = 0;
  localparam int K_I  = 1;
  localparam int K_LD = 2;
  localparam int K_ST = 3;
  localparam int K_BR = 4;
  localparam int K_NONE = 5;

  logic clk = 1'b0;
  logic rst;
  logic run;
  int   total = 0;
  int   bad   = 0;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .run (run),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Instruction-level reference decode from the RV32I subset rules.
  function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, output logic legal,
                                     output int kind, output logic [3:0] alu,
                                     output logic bsel, output logic [1:0] imm);
    legal = 1'b0; kind = K_NONE; alu = A_NOP; bsel = 1'b0; imm = 2'b00;
    if (op == 7'h33) begin
      kind = K_R;
      if (f7 == 7'h00) begin legal = 1'b1; alu = F3_TAB[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1'b1; alu = A_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1'b1; alu = A_SRA; end
    end else if (op == 7'h13) begin
      kind = K_I; bsel = 1'b1;
      if (f3 == 3'd1) begin legal = (f7 == 7'h00); alu = A_SLL; end
      else if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin legal = 1'b1; alu = A_SRL; end
        else if (f7 == 7'h20) begin legal = 1'b1; alu = A_SRA; end
      end else begin legal = 1'b1; alu = F3_TAB[f3]; end
    end else if (op == 7'h03 || op == 7'h23) begin
      kind = (op == 7'h03) ? K_LD : K_ST;
      legal = (f3 == 3'd2); alu = A_ADD; bsel = 1'b1;
      imm = (op == 7'h23) ? 2'b01 : 2'b00;
    end else if (op == 7'h63) begin
      kind = K_BR; legal = (f3 < 3'd2); alu = A_SUB; imm = 2'b10;
    end
  endfunction

  task automatic reset_and_start();
    bus.dmem_ready = 1'b0;
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("idle_after_reset", 32'(bus.state), 32'(IDLE));
    run = 1'b1;
    @(negedge clk);
    #1;
    check_output("fetch_after_run", 32'(bus.state), 32'(FETCH));
  endtask

  // Runs one instruction starting in FETCH; returns at the next FETCH
  // (legal) or after reset and restart (illegal).
  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic zero,
                                input int w, input string tag);
    logic legal, bsel, ex_b, exp_sel;
    logic [3:0] alu, ex_alu;
    logic [1:0] imm, ex_imm;
    int kind, exp_cycles, idx, v_state, v_strobe, v_alu, v_halt;
    bit is_mem, in_mem, has_wb, done, last;
    state_e exp_st;

    ref_decode(op, f3, f7, legal, kind, alu, bsel, imm);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7; bus.alu_zero = zero;

    if (!legal) begin
      v_halt = 0;
      for (int i = 0; i < 22; i++) begin
        bus.dmem_ready = ($urandom_range(0, 1) == 1);
        #1;
        if (i == 0) begin
          if (bus.state !== FETCH || bus.ir_en !== 1'b1) v_halt++;
        end else begin
          if (bus.state !== ((i == 1) ? DECODE : HALT)) v_halt++;
          if (bus.halted !== (i >= 2)) v_halt++;
          if ({bus.pc_en, bus.ir_en, bus.rf_we, bus.dmem_re, bus.dmem_we} !== 5'b0) v_halt++;
          if (i >= 2 && bus.alu_op !== A_NOP) v_halt++;
        end
        @(negedge clk);
      end
      #1;
      check_output({tag, "_halt_trace"}, 32'(v_halt), 32'd0);
      check_output({tag, "_halted"}, 32'(bus.halted), 32'd1);
      reset_and_start();
      return;
    end

    is_mem = (kind == K_LD || kind == K_ST);
    has_wb = (kind == K_R || kind == K_I || kind == K_LD);
    case (kind)
      K_BR:    exp_cycles = 3;
      K_ST:    exp_cycles = 4 + w;
      K_LD:    exp_cycles = 5 + w;
      default: exp_cycles = 4;
    endcase
    exp_sel = (kind == K_BR) ? ((f3 == 3'd0) ? zero : !zero) : 1'b0;

    idx = 0; done = 0; v_state = 0; v_strobe = 0; v_alu = 0;
    ex_alu = 4'hx; ex_b = 1'bx; ex_imm = 2'bxx;
    while (!done) begin
      in_mem = is_mem && idx >= 3 && idx <= 3 + w;
      if (in_mem) bus.dmem_ready = (idx == 3 + w);
      else bus.dmem_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (idx > 0 && bus.ir_en === 1'b1) begin
        done = 1;
      end else if (idx >= exp_cycles + 8) begin
        done = 1;
      end else begin
        last = (idx == exp_cycles - 1);
        if (idx == 0) exp_st = FETCH;
        else if (idx == 1) exp_st = DECODE;
        else if (idx == 2) exp_st = EXEC;
        else if (in_mem) exp_st = MEM;
        else exp_st = WB;
        if (idx >= exp_cycles || bus.state !== exp_st) v_state++;
        if (bus.ir_en !== (idx == 0)) v_strobe++;
        if (bus.pc_en !== last) v_strobe++;
        if (bus.rf_we !== (has_wb && last)) v_strobe++;
        if (bus.dmem_re !== (kind == K_LD && in_mem)) v_strobe++;
        if (bus.dmem_we !== (kind == K_ST && in_mem)) v_strobe++;
        if (bus.halted !== 1'b0) v_strobe++;
        if (bus.pc_en === 1'b1 && bus.pc_sel !== exp_sel) v_strobe++;
        if (bus.rf_we === 1'b1 && bus.wb_sel !== (kind == K_LD)) v_strobe++;
        if (idx == 2) begin
          ex_alu = bus.alu_op; ex_b = bus.b_sel; ex_imm = bus.imm_sel;
        end else if (in_mem) begin
          if (bus.alu_op !== A_ADD || bus.b_sel !== 1'b1) v_alu++;
        end else if (bus.alu_op !== A_NOP) begin
          v_alu++;
        end
        @(negedge clk);
        idx++;
      end
    end

    check_output({tag, "_cycles"}, 32'(idx), 32'(exp_cycles));
    check_output({tag, "_state_trace"}, 32'(v_state), 32'd0);
    check_output({tag, "_strobes"}, 32'(v_strobe), 32'd0);
    check_output({tag, "_alu_nop_mem"}, 32'(v_alu), 32'd0);
    if (!is_mem) check_output({tag, "_exec_alu_op"}, 32'(ex_alu), 32'(alu));
    check_output({tag, "_exec_b_sel"}, 32'(ex_b), 32'(bsel));
    if (kind != K_R) check_output({tag, "_exec_imm_sel"}, 32'(ex_imm), 32'(imm));
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;

    rst = 1'b0; run = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.alu_zero = 1'b0; bus.dmem_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_state",   32'(bus.state),   32'(IDLE));
    check_output("rst_pc_en",   32'(bus.pc_en),   32'd0);
    check_output("rst_pc_sel",  32'(bus.pc_sel),  32'd0);
    check_output("rst_ir_en",   32'(bus.ir_en),   32'd0);
    check_output("rst_rf_we",   32'(bus.rf_we),   32'd0);
    check_output("rst_wb_sel",  32'(bus.wb_sel),  32'd0);
    check_output("rst_b_sel",   32'(bus.b_sel),   32'd0);
    check_output("rst_imm_sel", 32'(bus.imm_sel), 32'd0);
    check_output("rst_alu_op",  32'(bus.alu_op),  32'(A_NOP));
    check_output("rst_dmem_re", 32'(bus.dmem_re), 32'd0);
    check_output("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check_output("rst_halted",  32'(bus.halted),  32'd0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_output("idle_without_run", 32'(bus.state), 32'(IDLE));
    check_output("idle_no_ir_en", 32'(bus.ir_en), 32'd0);
    run = 1'b1;
    @(negedge clk);
    #1;
    check_output("first_fetch", 32'(bus.state), 32'(FETCH));
    run = 1'b0;

    $display("[TB] directed instructions");
    apply_stimulus(7'h33, 3'd0, 7'h00, 1'b0, 0, "add");
    apply_stimulus(7'h63, 3'd1, 7'h00, 1'b0, 0, "bne_nz");
    apply_stimulus(7'h63, 3'd0, 7'h00, 1'b0, 0, "beq_nz");
    apply_stimulus(7'h63, 3'd0, 7'h00, 1'b1, 0, "beq_z");
    apply_stimulus(7'h03, 3'd2, 7'h00, 1'b0, 3, "load_w3");
    apply_stimulus(7'h23, 3'd2, 7'h00, 1'b0, 0, "store_w0");
    apply_stimulus(7'h13, 3'd5, 7'h20, 1'b0, 0, "srai");
    apply_stimulus(7'h33, 3'd5, 7'h20, 1'b0, 0, "sra");
    apply_stimulus(7'h7F, 3'd0, 7'h00, 1'b0, 0, "illegal_opc");
    apply_stimulus(7'h33, 3'd4, 7'h20, 1'b0, 0, "illegal_r");

    $display("[TB] reset during MEM");
    bus.opcode = 7'h03; bus.funct3 = 3'd2; bus.funct7 = 7'h00; bus.dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("mid_mem_re_before", 32'(bus.dmem_re), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("mid_mem_re_after", 32'(bus.dmem_re), 32'd0);
    check_output("mid_mem_state", 32'(bus.state), 32'(IDLE));
    check_output("mid_mem_alu_op", 32'(bus.alu_op), 32'(A_NOP));
    check_output("mid_mem_updates", 32'({bus.pc_en, bus.rf_we, bus.dmem_we}), 32'd0);
    reset_and_start();

    $display("[TB] random instructions");
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        default: op = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h33;
      endcase
      if ((op == 7'h03 || op == 7'h23) && $urandom_range(0, 3) != 0) f3 = 3'd2;
      else if (op == 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
      else f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      run = ($urandom_range(0, 1) == 1);
      apply_stimulus(op, f3, f7, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)),
                     $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
